// File: rtl/mux_pkg.sv
// Shared constants and types for the round-robin stream multiplexer.
// Latency: n/a (declarations only).  Backpressure: n/a.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;
    localparam int   XFER_CNT_W  = 16;

    // Occupancy of the one-entry output register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req bit at or after ptr, wrapping mod CH.
// Latency: combinational.  Backpressure: none, pure function of req/ptr.
module rr_pick #(
    parameter int  CH   = 4,
    localparam int SELW = $clog2(CH)
) (
    input  logic [CH-1:0]   req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    logic [SELW:0] pos;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (SELW + 1)'(k);
            if (pos >= (SELW + 1)'(CH)) begin
                pos = pos - (SELW + 1)'(CH);
            end
            if (req[pos[SELW-1:0]]) begin
                idx   = pos[SELW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux, manual or round-robin select; STREAM_MUX_XFER_CNT_EN builds xfer_cnt.
// Latency: 1 cycle from input acceptance to out_*; full throughput with out_ready high.
// Backpressure: in_ready only toward the chosen channel, and only when the output register can load.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int  CH   = 4,
    parameter int  W    = 4,
    localparam int SELW = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [CH*W-1:0]       in_data,
    input  logic [CH-1:0]         in_valid,
    output logic [CH-1:0]         in_ready,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       grant,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    state_t          state_q;
    state_t          state_d;
    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] rr_idx;
    logic            rr_found;
    logic [SELW-1:0] chosen;
    logic            pick_ok;
    logic            load_en;
    logic            accept;
    logic [W-1:0]    ch_dat;
    logic [SELW-1:0] ptr_next;

    rr_pick #(
        .CH (CH)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (ptr_q),
        .idx   (rr_idx),
        .found (rr_found)
    );

    assign out_valid = (state_q == ST_FULL);
    assign load_en   = !out_valid || out_ready;

    // A manual index beyond CH-1 (non-power-of-2 CH) selects nothing.
    always_comb begin
        if (mode == MODE_RR) begin
            chosen  = rr_idx;
            pick_ok = rr_found;
        end else begin
            chosen  = sel;
            pick_ok = ({1'b0, sel} < (SELW + 1)'(CH));
        end
    end

    always_comb begin
        in_ready = '0;
        ch_dat   = '0;
        for (int i = 0; i < CH; i++) begin
            if (chosen == SELW'(i)) begin
                ch_dat = in_data[i*W +: W];
                if (load_en && pick_ok) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

    assign accept   = |(in_ready & in_valid);
    assign ptr_next = (chosen == SELW'(CH - 1)) ? '0 : chosen + SELW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_en) begin
            state_d = accept ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            grant    <= '0;
            ptr_q    <= '0;
        end else if (accept) begin
            out_data <= ch_dat;
            grant    <= chosen;
            if (mode == MODE_RR) begin
                ptr_q <= ptr_next;
            end
        end
    end

`ifdef STREAM_MUX_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + XFER_CNT_W'(1);
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule
